vga_clock_render: RTL and testbench
===================================

# vga_clock_render

Pixel generator downstream of the VGA sync generator. It takes the pixel coordinates, the pixel enable and the raw hsync/vsync from the sync stage. It draws the RTC time as "HH:MM:SS" in a 2x-scaled 8x16 font, centred on a 640x480 frame. Time updates from the RTC controller are applied only at the start of vertical blanking, so the display never tears.

## Interface
Parameters:
- ORIGIN_X, 256: left pixel column of the text box (box is 128 px wide).
- ORIGIN_Y, 224: top pixel row of the text box (box is 32 px tall).
- FG_COLOR, 12'h0F0: {R4,G4,B4} colour for glyph pixels.
- BG_COLOR, 12'h000: colour for active-area pixels that are not glyph pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pix_en  in  1  pixel enable from the sync stage (ENclock); every pipeline stage advances only when this is 1.
- px_x  in  10  current column, 0..799.
- px_y  in  10  current row, 0..524.
- hsync_in  in  1  hsync from the sync stage.
- vsync_in  in  1  vsync from the sync stage.
- time_bcd  in  24  {hh, mm, ss}, two BCD nibbles each.
- time_valid  in  1  one-cycle strobe; time_bcd is valid in the same cycle.
- upd_ack  out  1  one-cycle pulse when the display registers load a new time.
- hsync  out  1  hsync_in delayed to align with rgb.
- vsync  out  1  vsync_in delayed to align with rgb.
- rgb  out  12  pixel colour.

## Operation
Update FSM, states IDLE and PENDING:
- time_valid=1 captures time_bcd into the pending register and moves to PENDING. A later time_valid before the frame start overwrites it; the latest value wins.
- Frame start (FS) is a cycle with pix_en=1, px_x=0 and px_y=480.
- FS while in PENDING: copy the pending register into the display register, set disp_ok, pulse upd_ack, go to IDLE.
- time_valid and FS in the same cycle: time_bcd loads straight into the display register, upd_ack pulses, state ends IDLE.
- FS while in IDLE: nothing changes.

Glyph codes:
- 0-9 are digits, 10 is ':', 11 is blank, 12 is '-'.
- A BCD nibble greater than 9 is shown as '-'.
- While disp_ok=0, all six digits are shown as '-'; the colons are always shown.

Pixel pipeline, stage S1 (on pix_en):
- dx = px_x - ORIGIN_X, dy = py_y - ORIGIN_Y, both 10-bit.
- in_box = (px_x >= ORIGIN_X) && (dx < 128) && (px_y >= ORIGIN_Y) && (dy < 32).
- Character column = dx[6:4], 0..7. Columns 2 and 5 are ':'; the rest are digits H1 H0 M1 M0 S1 S0.
- Glyph row = dy[4:1]; bit index = dx[3:1].
- ROM address = {code[3:0], row[3:0]}.
- Register in_box, bit index, active = (px_x < 640 && px_y < 480), hsync_in and vsync_in.

Pixel pipeline, stage S2 (on pix_en):
- Font ROM data is valid.
- pix = rom_data[7 - bit] & in_box.
- rgb = active ? (pix ? FG_COLOR : BG_COLOR) : 12'h000.
- hsync and vsync take their S1-stage copies.

When pix_en=0, every pipeline register and the ROM output hold.

## Timing
- Latency is exactly 2 pix_en cycles from px_x/px_y/hsync_in/vsync_in to rgb/hsync/vsync, identical for all outputs.
- upd_ack is asserted in the cycle after the FS cycle and lasts 1 clk.
- A new time value is first visible on the first active row of the next frame.
- Reset values:
  - rgb=0, hsync=0, vsync=0, upd_ack=0.
  - Update FSM = IDLE, disp_ok=0, all pipeline registers 0.
- rst during an active frame: outputs go to 0 on the next clk, and any pending value is discarded.
- px_x >= 640 or px_y >= 480 always gives rgb=0, regardless of the box parameters.

## Structure
- Package vga_pkg holds:
  - HD=640, VD=480.
  - Glyph code constants GLYPH_COLON=10, GLYPH_BLANK=11, GLYPH_DASH=12.
  - RGB_W=12.
  - Text box constants TXT_W=128, TXT_H=32.
- Sub-module font_rom:
  - 256x8 storage; 16 codes of 16 rows each; codes 13-15 are blank.
  - Synchronous read, enabled by pix_en.
  - MSB is the leftmost pixel.

## Test plan
- Reset then idle: rst for 3 cycles, then a full frame -> rgb=0 outside the box; box pixels show "--:--:--" in FG; upd_ack never pulses.
- Single update: time_valid with 24'h123456 mid-frame -> no glyph change that frame; upd_ack on FS+1; next frame renders "12:34:56"; pixel (256,224) comes out 2 pix_en later.
- Overwrite: time_valid 24'h010203 and then 24'h235959 in the same frame -> one upd_ack; "23:59:59" displayed.
- Coincident: time_valid 24'h000000 in the FS cycle -> upd_ack on the next clk; "00:00:00" next frame; FSM ends IDLE.
- Invalid BCD: 24'h1A5F00 -> "1-:5-:00".
- Alignment and reset mid-frame: sweep hsync_in/vsync_in -> outputs lag them by exactly 2 pix_en; asserting rst at px=(300,230) -> rgb=0 next clk and the pending value is dropped.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, glyph codes and update-FSM state type for the VGA clock renderer.
package vga_pkg;

    localparam int HD    = 640;
    localparam int VD    = 480;
    localparam int RGB_W = 12;
    localparam int TXT_W = 128;
    localparam int TXT_H = 32;

    localparam logic [3:0] GLYPH_COLON = 4'd10;
    localparam logic [3:0] GLYPH_BLANK = 4'd11;
    localparam logic [3:0] GLYPH_DASH  = 4'd12;

    typedef enum logic {
        UPD_IDLE,
        UPD_PENDING
    } upd_state_t;

    // Digits 0-9 map to their own glyph; invalid BCD or no time yet shows a dash.
    function automatic logic [3:0] digit_glyph(input logic [3:0] nib, input logic ok);
        return (!ok || nib > 4'd9) ? GLYPH_DASH : nib;
    endfunction

endpackage

// File: rtl/font_rom.sv
// 16 glyphs x 16 rows x 8 px font with a registered, enable-gated read port.
module font_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // One 128-bit word per glyph, row 0 in the top byte, MSB = leftmost pixel.
    localparam logic [127:0] GLYPHS [16] = '{
        128'h00007E42424242420042424242427E00,  // 0
        128'h00000002020202020002020202020000,  // 1
        128'h00007E02020202027E40404040407E00,  // 2
        128'h00007E02020202027E02020202027E00,  // 3
        128'h00000042424242427E02020202020000,  // 4
        128'h00007E40404040407E02020202027E00,  // 5
        128'h00007E40404040407E42424242427E00,  // 6
        128'h00007E02020202020002020202020000,  // 7
        128'h00007E42424242427E42424242427E00,  // 8
        128'h00007E42424242427E02020202027E00,  // 9
        128'h00000000001818000000181800000000,  // ':'
        128'h00000000000000000000000000000000,  // blank
        128'h00000000000000007E00000000000000,  // '-'
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000000
    };

    logic [127:0] glyph;

    always_comb glyph = GLYPHS[addr[7:4]];

    // NOTE: only the read register is reset; the glyph table is constant storage and needs none.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (en) begin
            data <= glyph[{~addr[3:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/vga_clock_render.sv
// Renders "HH:MM:SS" in a 2x-scaled 8x16 font; new times latch only at the start of vblank.
module vga_clock_render
    import vga_pkg::*;
#(
    parameter int               ORIGIN_X = 256,
    parameter int               ORIGIN_Y = 224,
    parameter logic [RGB_W-1:0] FG_COLOR = 12'h0F0,
    parameter logic [RGB_W-1:0] BG_COLOR = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic [9:0]       px_x,
    input  logic [9:0]       px_y,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [23:0]      time_bcd,
    input  logic             time_valid,
    output logic             upd_ack,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    upd_state_t  state, state_d;
    logic [23:0] pend_time, disp_time, disp_src;
    logic        disp_ok, pend_load, disp_load, frame_start;

    assign frame_start = pix_en && (px_x == 10'd0) && (px_y == 10'(VD));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        pend_load = 1'b0;
        disp_load = 1'b0;
        disp_src  = pend_time;
        if (frame_start && time_valid) begin
            disp_load = 1'b1;
            disp_src  = time_bcd;
            state_d   = UPD_IDLE;
        end else if (frame_start && state == UPD_PENDING) begin
            disp_load = 1'b1;
            state_d   = UPD_IDLE;
        end else if (time_valid) begin
            pend_load = 1'b1;
            state_d   = UPD_PENDING;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UPD_IDLE;
            pend_time <= '0;
            disp_time <= '0;
            disp_ok   <= 1'b0;
            upd_ack   <= 1'b0;
        end else begin
            state   <= state_d;
            upd_ack <= disp_load;
            if (pend_load) pend_time <= time_bcd;
            if (disp_load) begin
                disp_time <= disp_src;
                disp_ok   <= 1'b1;
            end
        end
    end

    // S1: locate the pixel inside the text box and form the font address.
    logic [9:0] dx, dy;
    logic [3:0] nib, code;
    logic [7:0] rom_addr, rom_data;
    logic       in_box, active;
    logic       s1_in_box, s1_active, s1_hs, s1_vs;
    logic [2:0] s1_bit;

    always_comb begin
        dx     = px_x - 10'(ORIGIN_X);
        dy     = px_y - 10'(ORIGIN_Y);
        in_box = (px_x >= 10'(ORIGIN_X)) && (dx < 10'(TXT_W)) &&
                 (px_y >= 10'(ORIGIN_Y)) && (dy < 10'(TXT_H));
        active = (px_x < 10'(HD)) && (px_y < 10'(VD));
        case (dx[6:4])
            3'd0:    nib = disp_time[23:20];
            3'd1:    nib = disp_time[19:16];
            3'd3:    nib = disp_time[15:12];
            3'd4:    nib = disp_time[11:8];
            3'd6:    nib = disp_time[7:4];
            3'd7:    nib = disp_time[3:0];
            default: nib = 4'd0;
        endcase
        code     = (dx[6:4] == 3'd2 || dx[6:4] == 3'd5) ? GLYPH_COLON : digit_glyph(nib, disp_ok);
        rom_addr = {code, dy[4:1]};
    end

    font_rom u_font_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_in_box <= 1'b0;
            s1_active <= 1'b0;
            s1_bit    <= '0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
        end else if (pix_en) begin
            s1_in_box <= in_box;
            s1_active <= active;
            s1_bit    <= dx[3:1];
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
        end
    end

    // S2: pick the colour; blanking always forces black.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (pix_en) begin
            hsync <= s1_hs;
            vsync <= s1_vs;
            if (!s1_active)                             rgb <= '0;
            else if (rom_data[3'd7 - s1_bit] && s1_in_box) rgb <= FG_COLOR;
            else                                        rgb <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_vga_clock_render.sv
// Randomized bench for vga_clock_render against a seven-segment style reference model.
module tb_vga_clock_render;

    localparam logic [11:0] FG = 12'h0F0;
    localparam logic [11:0] BG = 12'h005;

    logic        clk = 1'b0;
    logic        rst, pix_en, hsync_in, vsync_in, time_valid;
    logic [9:0]  px_x, px_y;
    logic [23:0] time_bcd;
    logic        upd_ack, hsync, vsync;
    logic [11:0] rgb;

    vga_clock_render #(
        .ORIGIN_X (256),
        .ORIGIN_Y (224),
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .px_x       (px_x),
        .px_y       (px_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .time_bcd   (time_bcd),
        .time_valid (time_valid),
        .upd_ack    (upd_ack),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          m_pend, m_ok;
    logic [23:0] m_pend_val, m_disp;
    logic [13:0] exp_q[$];
    logic [13:0] held;
    // Segments a..g as bits 6..0 for digits 0-9.
    bit [6:0]    seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    endtask

    // Glyph cell is 8 columns x 16 rows; digits drawn as 6-wide segments.
    function automatic bit glyph_on(int code, int row, int col);
        bit       h, up, lo;
        bit [6:0] s;
        h  = (col >= 1 && col <= 6);
        up = (row >= 3 && row <= 7);
        lo = (row >= 9 && row <= 13);
        if (code == 10) return (row == 5 || row == 6 || row == 10 || row == 11) && (col == 3 || col == 4);
        if (code == 12) return (row == 8) && h;
        s = seg_tab[code];
        return (s[6] && row == 2 && h)  || (s[5] && up && col == 6) || (s[4] && lo && col == 6) ||
               (s[3] && row == 14 && h) || (s[2] && lo && col == 1) || (s[1] && up && col == 1) ||
               (s[0] && row == 8 && h);
    endfunction

    function automatic int char_code(int ch);
        int k, nib;
        if (ch == 2 || ch == 5) return 10;
        k   = ch - ch / 3;  // skip the colon positions: 0,1,3,4,6,7 -> 0..5
        nib = int'((m_disp >> (20 - 4 * k)) & 24'hF);
        if (!m_ok || nib > 9) return 12;
        return nib;
    endfunction

    function automatic logic [13:0] model_out(int x, int y, bit hs, bit vs);
        logic [11:0] c;
        if (x >= 640 || y >= 480)                          c = 12'h000;
        else if (x >= 256 && x < 384 && y >= 224 && y < 256)
            c = glyph_on(char_code((x - 256) / 16), (y - 224) / 2, ((x - 256) % 16) / 2) ? FG : BG;
        else                                               c = BG;
        return {c, hs, vs};
    endfunction

    task automatic step(input int x, input int y, input bit en, input bit tv,
                        input logic [23:0] bcd, input bit r);
        bit hs, vs, fs, exp_ack;
        hs         = 1'($urandom);
        vs         = 1'($urandom);
        px_x       = 10'(x);
        px_y       = 10'(y);
        pix_en     = en;
        hsync_in   = hs;
        vsync_in   = vs;
        time_valid = tv;
        time_bcd   = bcd;
        rst        = r;
        fs         = en && x == 0 && y == 480;
        exp_ack    = 1'b0;
        if (r) begin
            m_pend = 1'b0;
            m_ok   = 1'b0;
            m_disp = '0;
        end else begin
            if (en) exp_q.push_back(model_out(x, y, hs, vs));
            if (fs && (tv || m_pend)) begin
                m_disp  = tv ? bcd : m_pend_val;
                m_ok    = 1'b1;
                m_pend  = 1'b0;
                exp_ack = 1'b1;
            end else if (tv) begin
                m_pend     = 1'b1;
                m_pend_val = bcd;
            end
        end
        @(posedge clk);
        #1;
        check("upd_ack", 32'(upd_ack), 32'(exp_ack));
        if (r) begin
            exp_q.delete();
            exp_q.push_back('0);
            held = '0;
            check("reset_out", 32'({rgb, hsync, vsync}), 32'h0);
        end else if (en) begin
            held = exp_q.pop_front();
            check("rgb", 32'(rgb), 32'(held[13:2]));
            check("sync", 32'({hsync, vsync}), 32'(held[1:0]));
        end else begin
            check("hold", 32'({rgb, hsync, vsync}), 32'(held));
        end
    endtask

    task automatic pix(input int x, input int y);
        if ($urandom_range(7) == 0) step($urandom_range(799), $urandom_range(524), 0, 0, '0, 0);
        step(x, y, 1, 0, '0, 0);
    endtask

    task automatic scan_box(input int ystep);
        for (int y = 223; y <= 256; y += ystep)
            for (int x = 254; x <= 385; x++) pix(x, y);
    endtask

    task automatic rand_pix(input int n);
        for (int i = 0; i < n; i++) pix($urandom_range(799), $urandom_range(479 + 45));
    endtask

    task automatic tv_at(input logic [23:0] bcd);
        step($urandom_range(799), $urandom_range(470), 1'($urandom), 1, bcd, 0);
    endtask

    task automatic frame_start();
        step(0, 480, 1, 0, '0, 0);
    endtask

    initial begin
        repeat (3) step($urandom_range(799), $urandom_range(524), 1, 0, '0, 1);

        // Idle after reset: dashes, no acknowledge at frame start.
        rand_pix(300);
        frame_start();
        scan_box(1);

        // Single update: old glyphs until the frame start, then the new time.
        rand_pix(50);
        tv_at(24'h123456);
        scan_box(1);
        frame_start();
        scan_box(1);

        // Latest of two updates in one frame wins.
        tv_at(24'h010203);
        rand_pix(40);
        tv_at(24'h235959);
        scan_box(2);
        frame_start();
        scan_box(1);

        // Update arriving in the frame-start cycle itself, then an empty frame start.
        step(0, 480, 1, 1, 24'h000000, 0);
        scan_box(1);
        frame_start();

        // Invalid BCD nibbles render as dashes.
        tv_at(24'h1A5F00);
        frame_start();
        scan_box(1);

        // Reset mid-frame discards the pending value.
        tv_at(24'h111111);
        for (int x = 290; x < 300; x++) pix(x, 230);
        step(300, 230, 1, 0, '0, 1);
        pix(301, 230);
        frame_start();
        scan_box(1);

        // Random update sequences with random BCD contents.
        repeat (3) begin
            repeat ($urandom_range(1, 3)) tv_at(24'($urandom));
            rand_pix(100);
            frame_start();
            scan_box(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
